// File: rtl/axi_lite_fifo_bridge.sv
// AXI4-Lite slave exposing a synchronous FIFO as CONTROL / DATA_IN / DATA_OUT / STATUS registers.
// Pushes execute when both AW and W beats are held; pops execute on the AR handshake.
module axi_lite_fifo_bridge #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_WIDTH         = 8,
    parameter int FIFO_DEPTH         = 16,
    parameter int AF_THRESH          = 12
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            irq
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_CONTROL  = 2'd0,
        REG_DATA_IN  = 2'd1,
        REG_DATA_OUT = 2'd2,
        REG_STATUS   = 2'd3
    } reg_sel_e;

    // Handshake rule: a beat transfers on the rising edge where valid and ready are both 1;
    // a source holds valid and payload stable until then.

    logic                  r_awready;
    logic                  r_wready;
    logic                  r_aw_full;
    logic                  r_w_full;
    reg_sel_e              r_aw_sel;
    logic [DW-1:0]         r_wdata;
    logic                  r_wstrb0;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DW-1:0]         r_rdata;

    logic                  r_en;
    logic                  r_irq_en;
    logic                  r_ovf;
    logic                  r_unf;

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_wr_exec;
    logic                  w_aw_full_nxt;
    logic                  w_w_full_nxt;
    logic                  w_bvalid_nxt;
    reg_sel_e              w_ar_sel;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_afull;
    logic                  w_push_req;
    logic                  w_push_ok;
    logic                  w_pop_req;
    logic                  w_pop_ok;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic                  w_flush;
    logic                  w_ctrl_wr;
    logic                  w_status_clr;
    logic [1:0]            w_wr_resp;
    logic [DW-1:0]         w_status;
    logic [DW-1:0]         w_head_ext;
    logic [DW-1:0]         w_rd_data;
    logic [1:0]            w_rd_resp;
    logic                  w_unused;

    assign w_aw_hs   = s_axi_awvalid & r_awready;
    assign w_w_hs    = s_axi_wvalid & r_wready;
    assign w_b_hs    = r_bvalid & s_axi_bready;
    assign w_ar_hs   = s_axi_arvalid & r_arready;
    assign w_r_hs    = r_rvalid & s_axi_rready;
    assign w_wr_exec = r_aw_full & r_w_full & ~r_bvalid;

    assign w_aw_full_nxt = (r_aw_full | w_aw_hs) & ~w_wr_exec;
    assign w_w_full_nxt  = (r_w_full | w_w_hs) & ~w_wr_exec;
    assign w_bvalid_nxt  = w_wr_exec | (r_bvalid & ~w_b_hs);

    assign w_ar_sel = reg_sel_e'(s_axi_araddr[3:2]);
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_afull  = (r_count >= CNT_W'(AF_THRESH));

    // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
    assign w_pop_req    = w_ar_hs & (w_ar_sel == REG_DATA_OUT);
    assign w_pop_ok     = w_pop_req & r_en & ~w_empty;
    assign w_unf_set    = w_pop_req & r_en & w_empty;
    assign w_push_req   = w_wr_exec & (r_aw_sel == REG_DATA_IN);
    assign w_push_ok    = w_push_req & r_en & (~w_full | w_pop_ok);
    assign w_ovf_set    = w_push_req & r_en & w_full & ~w_pop_ok;
    assign w_ctrl_wr    = w_wr_exec & (r_aw_sel == REG_CONTROL) & r_wstrb0;
    assign w_flush      = w_ctrl_wr & r_wdata[1];
    assign w_status_clr = w_wr_exec & (r_aw_sel == REG_STATUS);
    assign w_wr_resp    = (w_push_req & ~w_push_ok) ? RESP_SLVERR : RESP_OKAY;

    assign irq = r_irq_en & ~w_empty;

    always_comb begin
        w_status               = '0;
        w_status[0]            = w_empty;
        w_status[1]            = w_full;
        w_status[2]            = w_afull;
        w_status[3]            = r_ovf;
        w_status[4]            = r_unf;
        w_status[8 +: CNT_W]   = r_count;

        w_head_ext                   = '0;
        w_head_ext[FIFO_WIDTH-1:0]   = r_mem[r_rptr];

        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_ar_sel)
            REG_CONTROL: begin
                w_rd_data[0] = r_en;
                w_rd_data[2] = r_irq_en;
            end
            REG_DATA_OUT: begin
                if (w_pop_ok) w_rd_data = w_head_ext;
                else          w_rd_resp = RESP_SLVERR;
            end
            REG_STATUS: w_rd_data = w_status;
            default: ;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_sel  <= REG_CONTROL;
            r_wdata   <= '0;
            r_wstrb0  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_awready <= ~w_aw_full_nxt & ~w_bvalid_nxt;
            r_wready  <= ~w_w_full_nxt & ~w_bvalid_nxt;
            r_bvalid  <= w_bvalid_nxt;
            if (w_aw_hs) r_aw_sel <= reg_sel_e'(s_axi_awaddr[3:2]);
            if (w_w_hs) begin
                r_wdata  <= s_axi_wdata;
                r_wstrb0 <= s_axi_wstrb[0];
            end
            if (w_wr_exec) r_bresp <= w_wr_resp;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_arready <= ~(w_ar_hs | (r_rvalid & ~w_r_hs));
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Set wins over a same-cycle W1C so an error event is never silently lost.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_en     <= r_wdata[0];
                r_irq_en <= r_wdata[2];
            end
            if (w_ovf_set)                      r_ovf <= 1'b1;
            else if (w_status_clr & r_wdata[3]) r_ovf <= 1'b0;
            if (w_unf_set)                      r_unf <= 1'b1;
            else if (w_status_clr & r_wdata[4]) r_unf <= 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (w_push_ok) r_mem[r_wptr] <= r_wdata[FIFO_WIDTH-1:0];
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;

    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb, r_wdata};

endmodule

// File: tb/tb_axi_lite_fifo_bridge.sv
// Randomised scoreboard bench for axi_lite_fifo_bridge against a queue-based register model.
module tb_axi_lite_fifo_bridge;

    localparam int DEPTH = 16;
    localparam int FW    = 8;
    localparam int AF    = 12;
    localparam int TMO   = 100;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLV  = 2'b10;

    logic        clk;
    logic        rst;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        irq;

    axi_lite_fifo_bridge #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4),
        .FIFO_WIDTH(FW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .irq(irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];

    // reference model
    logic [FW-1:0] m_q[$];
    bit m_en, m_irq_en, m_ovf, m_unf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string what);
        n_tests++;
        n_fail++;
        $display("FAIL timeout_%s: no handshake within %0d cycles at %0t", what, TMO, $time);
    endtask

    function automatic void m_reset();
        m_q.delete();
        m_en = 0; m_irq_en = 0; m_ovf = 0; m_unf = 0;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = (m_q.size() == 0);
        s[1] = (m_q.size() == DEPTH);
        s[2] = (m_q.size() >= AF);
        s[3] = m_ovf;
        s[4] = m_unf;
        s[15:8] = 8'(m_q.size());
        return s;
    endfunction

    function automatic logic [1:0] m_write(input logic [3:0] addr, input logic [31:0] d,
                                           input logic [3:0] strb);
        case (addr[3:2])
            2'd0: if (strb[0]) begin
                m_en = d[0];
                m_irq_en = d[2];
                if (d[1]) m_q.delete();
            end
            2'd1: begin
                if (!m_en) return SLV;
                if (m_q.size() == DEPTH) begin
                    m_ovf = 1;
                    return SLV;
                end
                m_q.push_back(d[FW-1:0]);
            end
            2'd3: begin
                if (d[3]) m_ovf = 0;
                if (d[4]) m_unf = 0;
            end
            default: ;
        endcase
        return OKAY;
    endfunction

    function automatic logic [33:0] m_read(input logic [3:0] addr);
        logic [33:0] r;
        r = '0;
        case (addr[3:2])
            2'd0: r[31:0] = {29'd0, m_irq_en, 1'b0, m_en};
            2'd2: begin
                if (!m_en) r[33:32] = SLV;
                else if (m_q.size() == 0) begin
                    r[33:32] = SLV;
                    m_unf = 1;
                end else r[31:0] = 32'(m_q.pop_front());
            end
            2'd3: r[31:0] = m_status();
            default: ;
        endcase
        return r;
    endfunction

    // driver tasks: callers start and end just after a rising edge
    task automatic do_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        exp_b_q.push_back(m_write(addr, d, strb));
        fork
            begin
                repeat (aw_dly) @(posedge clk);
                #1 s_axi_awaddr = addr;
                s_axi_awvalid = 1'b1;
                for (int k = 0; k <= TMO; k++) begin
                    @(negedge clk);
                    if (s_axi_awready) break;
                    if (k == TMO) tmo("awready");
                end
                @(posedge clk);
                #1 s_axi_awvalid = 1'b0;
            end
            begin
                repeat (w_dly) @(posedge clk);
                #1 s_axi_wdata = d;
                s_axi_wstrb = strb;
                s_axi_wvalid = 1'b1;
                for (int k = 0; k <= TMO; k++) begin
                    @(negedge clk);
                    if (s_axi_wready) break;
                    if (k == TMO) tmo("wready");
                end
                @(posedge clk);
                #1 s_axi_wvalid = 1'b0;
            end
        join
        repeat (b_dly) @(posedge clk);
        #1 s_axi_bready = 1'b1;
        for (int k = 0; k <= TMO; k++) begin
            @(negedge clk);
            if (s_axi_bvalid) break;
            if (k == TMO) tmo("bvalid");
        end
        @(posedge clk);
        #1 s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] addr, input int r_dly);
        exp_r_q.push_back(m_read(addr));
        s_axi_araddr = addr;
        s_axi_arvalid = 1'b1;
        for (int k = 0; k <= TMO; k++) begin
            @(negedge clk);
            if (s_axi_arready) break;
            if (k == TMO) tmo("arready");
        end
        @(posedge clk);
        #1 s_axi_arvalid = 1'b0;
        repeat (r_dly) @(posedge clk);
        #1 s_axi_rready = 1'b1;
        for (int k = 0; k <= TMO; k++) begin
            @(negedge clk);
            if (s_axi_rvalid) break;
            if (k == TMO) tmo("rvalid");
        end
        @(posedge clk);
        #1 s_axi_rready = 1'b0;
    endtask

    // push executes on the same edge as the pop's AR handshake
    task automatic do_push_pop(input logic [31:0] d);
        logic [33:0] r;
        logic [1:0]  b;
        bit pop_ok;
        pop_ok = m_en && (m_q.size() != 0);
        r = '0;
        if (!m_en) r[33:32] = SLV;
        else if (!pop_ok) begin
            r[33:32] = SLV;
            m_unf = 1;
        end else r[31:0] = 32'(m_q[0]);
        b = OKAY;
        if (!m_en) b = SLV;
        else if (m_q.size() < DEPTH || pop_ok) m_q.push_back(d[FW-1:0]);
        else begin
            b = SLV;
            m_ovf = 1;
        end
        if (pop_ok) void'(m_q.pop_front());
        exp_b_q.push_back(b);
        exp_r_q.push_back(r);

        s_axi_awaddr = 4'h4;
        s_axi_wdata = d;
        s_axi_wstrb = 4'hf;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        check("pp_aw_w_ready", {s_axi_awready, s_axi_wready}, 2'b11);
        @(posedge clk);
        #1 s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        s_axi_araddr = 4'h8;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        check("pp_arready", s_axi_arready, 1'b1);
        @(posedge clk);
        #1 s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        for (int k = 0; k <= TMO; k++) begin
            @(posedge clk);
            if (exp_b_q.size() == 0 && exp_r_q.size() == 0) break;
            if (k == TMO) tmo("push_pop_resp");
        end
        #1 s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
    endtask

    task automatic check_irq(input string name);
        check(name, irq, m_irq_en && (m_q.size() != 0));
    endtask

    // scoreboard monitor
    logic        prev_bvalid, prev_bready, prev_rvalid, prev_rready;
    logic [1:0]  prev_bresp, prev_rresp;
    logic [31:0] prev_rdata;

    always @(negedge clk) begin
        if (rst) begin
            prev_bvalid = 1'b0;
            prev_bready = 1'b0;
            prev_rvalid = 1'b0;
            prev_rready = 1'b0;
        end else begin
            if (prev_bvalid && !prev_bready) begin
                check("bvalid_hold", s_axi_bvalid, 1'b1);
                check("bresp_stable", s_axi_bresp, prev_bresp);
            end
            if (prev_rvalid && !prev_rready) begin
                check("rvalid_hold", s_axi_rvalid, 1'b1);
                check("r_stable", {s_axi_rresp, s_axi_rdata}, {prev_rresp, prev_rdata});
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_b: bresp 0x%0h, required no response", s_axi_bresp);
                end else check("bresp", s_axi_bresp, exp_b_q.pop_front());
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_r: rdata 0x%0h, required no response", s_axi_rdata);
                end else check("rresp_rdata", {s_axi_rresp, s_axi_rdata}, exp_r_q.pop_front());
            end
            prev_bvalid = s_axi_bvalid;
            prev_bready = s_axi_bready;
            prev_bresp  = s_axi_bresp;
            prev_rvalid = s_axi_rvalid;
            prev_rready = s_axi_rready;
            prev_rresp  = s_axi_rresp;
            prev_rdata  = s_axi_rdata;
        end
    end

    initial begin
        int op;
        logic [31:0] d;
        logic [1:0]  lo;
        logic [3:0]  strb;

        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        m_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl_outs", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                                s_axi_rvalid, irq, s_axi_bresp, s_axi_rresp}, '0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        @(posedge clk);
        #1;

        // T1
        do_write(4'h0, 32'h1, 4'hf, 0, 0, 0);
        do_write(4'h4, 32'hA5, 4'hf, 0, 0, 0);
        do_write(4'h4, 32'h3C, 4'h0, 1, 0, 2);
        do_read(4'h8, 0);
        do_read(4'h8, 3);
        do_read(4'hC, 0);

        // T2
        for (int i = 0; i < DEPTH; i++)
            do_write(4'h4, $urandom(), 4'hf, $urandom_range(0, 2), $urandom_range(0, 2), 0);
        do_read(4'hC, 0);
        do_write(4'h4, 32'hFF, 4'hf, 0, 0, 0);
        do_read(4'hC, 1);

        // T3
        for (int i = 0; i < DEPTH; i++) do_read(4'h8, $urandom_range(0, 2));
        do_read(4'h8, 0);
        do_read(4'hC, 0);
        do_write(4'hC, 32'h18, 4'hf, 0, 0, 0);
        do_read(4'hC, 0);

        // T4
        do_write(4'h4, 32'h5A, 4'hf, 3, 0, 7);
        do_read(4'hC, 0);
        do_read(4'h8, 0);

        // disabled FIFO and unmapped accesses
        do_write(4'h4, 32'h11, 4'hf, 0, 0, 0);
        do_write(4'h0, 32'h0, 4'hf, 0, 0, 0);
        do_write(4'h4, 32'h22, 4'hf, 0, 0, 0);
        do_read(4'h8, 0);
        do_read(4'hC, 0);
        do_write(4'h0, 32'h1, 4'hf, 0, 0, 0);
        do_read(4'h4, 0);
        do_write(4'h8, 32'h77, 4'hf, 0, 0, 0);
        do_read(4'h0, 0);
        do_read(4'h8, 0);

        // T5
        while (m_q.size() < DEPTH) do_write(4'h4, $urandom(), 4'hf, 0, 0, 0);
        for (int i = 0; i < 3 * DEPTH; i++) do_push_pop($urandom());
        do_read(4'hC, 0);
        while (m_q.size() > 0) do_read(4'h8, 0);

        // T6
        for (int i = 0; i < 5; i++) do_write(4'h4, $urandom(), 4'hf, 0, 0, 0);
        do_read(4'hC, 0);
        do_write(4'h0, 32'h3, 4'hf, 0, 0, 0);
        do_read(4'hC, 0);
        do_write(4'h0, 32'h5, 4'hf, 0, 0, 0);
        check_irq("irq_empty");
        do_write(4'h4, 32'h99, 4'hf, 0, 0, 0);
        check_irq("irq_pushed");
        do_push_pop(32'h42);
        do_read(4'h8, 0);
        do_push_pop(32'h43);
        check_irq("irq_after_pp");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 11);
            d = $urandom();
            lo = 2'($urandom_range(0, 3));
            strb = 4'($urandom_range(0, 15));
            case (op)
                0, 1, 2, 3: do_write({2'd1, lo}, d, strb, $urandom_range(0, 3),
                                     $urandom_range(0, 3), $urandom_range(0, 3));
                4, 5, 6: do_read({2'd2, lo}, $urandom_range(0, 3));
                7: do_read({2'd3, lo}, $urandom_range(0, 2));
                8: begin
                    d = {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                         1'($urandom_range(0, 5) != 0)};
                    strb = ($urandom_range(0, 5) == 0) ? 4'he : 4'hf;
                    do_write({2'd0, lo}, d, strb, $urandom_range(0, 2), $urandom_range(0, 2), 0);
                end
                9: do_push_pop(d);
                10: do_write({2'd3, lo}, d, strb, 0, $urandom_range(0, 2), 1);
                default: begin
                    do_write({2'd2, lo}, d, strb, 0, 0, 0);
                    do_read({2'($urandom_range(0, 1)), lo}, 0);
                end
            endcase
            check_irq("irq_random");
        end

        // reset with a captured AW beat pending
        s_axi_awaddr = 4'h4;
        s_axi_awvalid = 1'b1;
        @(negedge clk);
        check("pre_rst_awready", s_axi_awready, 1'b1);
        @(posedge clk);
        #1 s_axi_awvalid = 1'b0;
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_b_after_rst", s_axi_bvalid, 1'b0);
        end
        @(posedge clk);
        #1;
        do_read(4'hC, 0);
        do_read(4'h0, 0);
        do_write(4'h0, 32'h1, 4'hf, 0, 0, 0);
        do_write(4'h4, 32'hC3, 4'hf, 0, 0, 0);
        do_read(4'hC, 0);
        do_read(4'h8, 0);

        repeat (3) @(posedge clk);
        check("b_queue_drained", exp_b_q.size(), 0);
        check("r_queue_drained", exp_r_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
